// File: rtl/uart_rx_core.sv
// UART receive engine: 16x oversampled deframer with optional parity check,
// FWFT receive FIFO, sticky error flags and a registered interrupt.
module uart_rx_core #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned DIV_W      = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        uart_clk,
   input  logic                        uart_rst,
   input  logic                        cfg_en,
   input  logic [DIV_W-1:0]            cfg_div,
   input  logic                        cfg_par_en,
   input  logic                        cfg_par_odd,
   input  logic                        uart_rx,
   output logic [DATA_BITS-1:0]        rx_data,
   output logic                        rx_valid,
   input  logic                        rx_ready,
   output logic [$clog2(FIFO_DEPTH):0] rx_level,
   output logic                        rx_frame_err,
   output logic                        rx_par_err,
   output logic                        rx_overrun,
   input  logic                        err_clr,
   output logic                        rx_irq
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned BW = $clog2(DATA_BITS + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
   localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t                 state_q, state_d;
   logic                   rx_s1_q, rx_s2_q, rx_s3_q;
   logic [DIV_W-1:0]       tick_cnt_q, tick_cnt_d;
   logic [3:0]             samp_cnt_q, samp_cnt_d;
   logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   par_bad_q, par_bad_d;
   logic                   tick, push, set_ferr, set_perr;

   logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]            cnt_q, cnt_d;
   logic                   ferr_q, ferr_d, perr_q, perr_d, ovr_q, ovr_d, irq_q;
   logic                   pop, full, wr_en;

   // Deframer. A '>=' wrap compare keeps the tick alive if cfg_div shrinks mid-frame.
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = '0;
      samp_cnt_d = samp_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_bad_d  = par_bad_q;
      push       = 1'b0;
      set_ferr   = 1'b0;
      set_perr   = 1'b0;
      tick       = (tick_cnt_q >= cfg_div);
      if (state_q != S_IDLE) begin
         tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
         if (tick) samp_cnt_d = samp_cnt_q + 1'b1;
      end
      unique case (state_q)
         S_IDLE: begin
            samp_cnt_d = '0;
            bit_cnt_d  = '0;
            par_bad_d  = 1'b0;
            if (!rx_s2_q && rx_s3_q) state_d = S_START;
         end
         S_START: begin
            if (tick && samp_cnt_q == 4'd7) begin
               samp_cnt_d = '0;
               state_d    = rx_s2_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (tick && samp_cnt_q == 4'hF) begin
               shift_d   = {rx_s2_q, shift_q[DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == LAST_BIT) state_d = cfg_par_en ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (tick && samp_cnt_q == 4'hF) begin
               par_bad_d = rx_s2_q ^ (^shift_q) ^ cfg_par_odd;
               state_d   = S_STOP;
            end
         end
         S_STOP: begin
            if (tick && samp_cnt_q == 4'hF) begin
               state_d  = S_IDLE;
               set_ferr = !rx_s2_q;
               set_perr = par_bad_q;
               push     = rx_s2_q && !par_bad_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (!cfg_en) begin
         state_d    = S_IDLE;
         tick_cnt_d = '0;
         push       = 1'b0;
         set_ferr   = 1'b0;
         set_perr   = 1'b0;
      end
   end

   always_comb begin
      pop      = (cnt_q != '0) && rx_ready;
      full     = (cnt_q == FULL_LVL);
      wr_en    = push && (!full || pop);
      wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_d    = cnt_q;
      if (wr_en && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !wr_en) cnt_d = cnt_q - 1'b1;
      // A set in the same cycle as err_clr wins.
      ferr_d = (ferr_q && !err_clr) || set_ferr;
      perr_d = (perr_q && !err_clr) || set_perr;
      ovr_d  = (ovr_q && !err_clr) || (push && full && !pop);
   end

   always_ff @(posedge uart_clk) begin
      if (uart_rst) begin
         state_q    <= S_IDLE;
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_s3_q    <= 1'b1;
         tick_cnt_q <= '0;
         samp_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_bad_q  <= 1'b0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         ferr_q     <= 1'b0;
         perr_q     <= 1'b0;
         ovr_q      <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_s1_q    <= uart_rx;
         rx_s2_q    <= rx_s1_q;
         rx_s3_q    <= rx_s2_q;
         tick_cnt_q <= tick_cnt_d;
         samp_cnt_q <= samp_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_bad_q  <= par_bad_d;
         if (wr_en) mem_q[wr_ptr_q] <= shift_q;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         ferr_q     <= ferr_d;
         perr_q     <= perr_d;
         ovr_q      <= ovr_d;
         irq_q      <= (cnt_d != '0) || ferr_d || perr_d || ovr_d;
      end
   end

   assign rx_data      = mem_q[rd_ptr_q];
   assign rx_valid     = (cnt_q != '0);
   assign rx_level     = cnt_q;
   assign rx_frame_err = ferr_q;
   assign rx_par_err   = perr_q;
   assign rx_overrun   = ovr_q;
   assign rx_irq       = irq_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed vector table, hand-written
// corner sequences and randomized frames against a queue-based reference model.
module tb_uart_rx_core;
   logic        uart_clk = 1'b0;
   logic        uart_rst, cfg_en, cfg_par_en, cfg_par_odd, uart_rx, rx_ready, err_clr;
   logic [15:0] cfg_div;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_frame_err, rx_par_err, rx_overrun, rx_irq;
   logic [2:0]  rx_level;

   int n_cmp  = 0;
   int n_bad  = 0;
   int bitclk = 64;
   int rise   = 0;

   logic [7:0] exp_q[$];
   bit         m_ferr, m_perr, m_ovr;

   typedef struct {
      logic [7:0] d;
      bit pen, podd, pbit, stop;
      bit e_push, e_ferr, e_perr;
   } vec_t;
   vec_t vecs[8];

   uart_rx_core #(.DATA_BITS(8), .DIV_W(16), .FIFO_DEPTH(4)) dut (
      .uart_clk(uart_clk), .uart_rst(uart_rst), .cfg_en(cfg_en), .cfg_div(cfg_div),
      .cfg_par_en(cfg_par_en), .cfg_par_odd(cfg_par_odd), .uart_rx(uart_rx),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_level(rx_level),
      .rx_frame_err(rx_frame_err), .rx_par_err(rx_par_err), .rx_overrun(rx_overrun),
      .err_clr(err_clr), .rx_irq(rx_irq)
   );

   always #5 uart_clk = ~uart_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ".level"}, rx_level, exp_q.size());
      check({tag, ".valid"}, rx_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) check({tag, ".data"}, rx_data, exp_q[0]);
      check({tag, ".ferr"}, rx_frame_err, m_ferr);
      check({tag, ".perr"}, rx_par_err, m_perr);
      check({tag, ".ovr"}, rx_overrun, m_ovr);
      check({tag, ".irq"}, rx_irq, (exp_q.size() != 0) || m_ferr || m_perr || m_ovr);
   endtask

   task automatic set_div(input int d);
      cfg_div = 16'(d);
      bitclk  = 16 * (d + 1);
   endtask

   task automatic send_bit(input logic b);
      uart_rx = b;
      repeat (bitclk) @(negedge uart_clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit, input bit stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      if (pen) send_bit(pbit);
      send_bit(stop);
      uart_rx = 1'b1;
   endtask

   task automatic gap();
      repeat (16) @(negedge uart_clk);
   endtask

   // Frame outcome from the line-level rules: keep only well-stopped, correctly
   // parity-protected bytes; a full queue drops the byte and flags overrun.
   task automatic model_frame(input logic [7:0] d, input bit pen, input bit podd,
                              input bit pbit, input bit stop);
      bit pbad;
      pbad = pen && (pbit != ((^d) ^ podd));
      if (!stop) m_ferr = 1'b1;
      if (pbad)  m_perr = 1'b1;
      if (stop && !pbad) begin
         if (exp_q.size() == 4) m_ovr = 1'b1;
         else exp_q.push_back(d);
      end
   endtask

   task automatic pop_one(input string tag);
      if (exp_q.size() != 0) check({tag, ".pop"}, rx_data, exp_q[0]);
      rx_ready = 1'b1;
      @(negedge uart_clk);
      rx_ready = 1'b0;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
   endtask

   task automatic clear_err();
      err_clr = 1'b1;
      @(negedge uart_clk);
      err_clr = 1'b0;
      m_ferr = 1'b0;
      m_perr = 1'b0;
      m_ovr  = 1'b0;
   endtask

   task automatic drain(input string tag);
      while (exp_q.size() != 0) pop_one(tag);
   endtask

   initial begin
      vecs[0] = '{8'h3C, 0, 0, 0, 0, 0, 1, 0};
      vecs[1] = '{8'h01, 1, 1, 1, 1, 0, 0, 1};
      vecs[2] = '{8'h01, 1, 1, 0, 1, 1, 0, 0};
      vecs[3] = '{8'h00, 1, 0, 0, 1, 1, 0, 0};
      vecs[4] = '{8'hFF, 1, 0, 1, 1, 0, 0, 1};
      vecs[5] = '{8'h7F, 1, 1, 0, 1, 1, 0, 0};
      vecs[6] = '{8'h80, 0, 0, 0, 1, 1, 0, 0};
      vecs[7] = '{8'h55, 1, 0, 1, 0, 0, 1, 1};

      uart_rst = 1'b1; cfg_en = 1'b1; cfg_par_en = 1'b0; cfg_par_odd = 1'b0;
      uart_rx = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
      set_div(3);
      repeat (3) @(negedge uart_clk);
      check("reset.data", rx_data, 0);
      check("reset.irq", rx_irq, 0);
      uart_rst = 1'b0;
      @(negedge uart_clk);
      check_state("reset");

      // 8N1 0xA5: rx_valid rises one clock after the mid-stop sample (~9.5 bits + sync).
      fork
         send_frame(8'hA5, 0, 0, 1);
         begin
            for (int c = 1; c <= 800; c++) begin
               @(posedge uart_clk); #1;
               if (rx_valid) begin rise = c; break; end
            end
         end
      join
      check("t1.latency_ok", (rise >= 600) && (rise <= 620), 1);
      model_frame(8'hA5, 0, 0, 0, 1);
      gap();
      check_state("t1");
      pop_one("t1");
      check_state("t1.after_pop");
      if (rise < 600 || rise > 620) rise = 611;

      rx_ready = 1'b1;
      repeat (3) @(negedge uart_clk);
      rx_ready = 1'b0;
      check_state("pop_empty");

      // 20-clock low glitch must be rejected and leave the receiver usable.
      uart_rx = 1'b0;
      repeat (20) @(negedge uart_clk);
      uart_rx = 1'b1;
      repeat (200) @(negedge uart_clk);
      check_state("glitch");
      send_frame(8'h96, 0, 0, 1);
      model_frame(8'h96, 0, 0, 0, 1);
      gap();
      check_state("glitch.next");
      drain("glitch");

      foreach (vecs[i]) begin
         drain("vec");
         clear_err();
         cfg_par_en = vecs[i].pen; cfg_par_odd = vecs[i].podd;
         send_frame(vecs[i].d, vecs[i].pen, vecs[i].pbit, vecs[i].stop);
         model_frame(vecs[i].d, vecs[i].pen, vecs[i].podd, vecs[i].pbit, vecs[i].stop);
         gap();
         check($sformatf("vec%0d.level", i), rx_level, vecs[i].e_push);
         if (vecs[i].e_push) check($sformatf("vec%0d.data", i), rx_data, vecs[i].d);
         check($sformatf("vec%0d.ferr", i), rx_frame_err, vecs[i].e_ferr);
         check($sformatf("vec%0d.perr", i), rx_par_err, vecs[i].e_perr);
         check($sformatf("vec%0d.irq", i), rx_irq,
               vecs[i].e_push | vecs[i].e_ferr | vecs[i].e_perr);
         clear_err();
         check($sformatf("vec%0d.clr_ferr", i), rx_frame_err, 0);
         check($sformatf("vec%0d.clr_irq", i), rx_irq, vecs[i].e_push);
      end
      drain("vec");
      cfg_par_en = 1'b0; cfg_par_odd = 1'b0;

      // Five frames into a 4-deep FIFO with no consumer.
      for (int i = 0; i < 5; i++) begin
         send_frame(8'h10 + 8'(i), 0, 0, 1);
         model_frame(8'h10 + 8'(i), 0, 0, 0, 1);
         gap();
      end
      check_state("ovr");
      drain("ovr");
      check_state("ovr.drained");
      clear_err();

      // Full FIFO with a pop coincident with the fifth commit: no overrun.
      for (int i = 0; i < 4; i++) begin
         send_frame(8'h20 + 8'(i), 0, 0, 1);
         model_frame(8'h20 + 8'(i), 0, 0, 0, 1);
         gap();
      end
      check_state("coinc.full");
      fork
         send_frame(8'h24, 0, 0, 1);
         begin
            repeat (rise - 1) @(posedge uart_clk);
            @(negedge uart_clk); rx_ready = 1'b1;
            @(negedge uart_clk); rx_ready = 1'b0;
         end
      join
      void'(exp_q.pop_front());
      model_frame(8'h24, 0, 0, 0, 1);
      gap();
      check_state("coinc");
      drain("coinc");

      // Receiver disabled mid-frame: partial frame dropped, FIFO kept.
      send_frame(8'h33, 0, 0, 1);
      model_frame(8'h33, 0, 0, 0, 1);
      gap();
      fork
         send_frame(8'hAA, 0, 0, 1);
         begin repeat (200) @(negedge uart_clk); cfg_en = 1'b0; end
      join
      gap();
      cfg_en = 1'b1;
      gap();
      check_state("disable");
      drain("disable");

      // Break: one frame error, no re-trigger while the line stays low.
      uart_rx = 1'b0;
      repeat (bitclk * 12) @(negedge uart_clk);
      model_frame(8'h00, 0, 0, 0, 0);
      check_state("break");
      clear_err();
      repeat (bitclk * 6) @(negedge uart_clk);
      check_state("break.held");
      uart_rx = 1'b1;
      repeat (bitclk * 2) @(negedge uart_clk);
      send_frame(8'hC3, 0, 0, 1);
      model_frame(8'hC3, 0, 0, 0, 1);
      gap();
      check_state("break.next");

      // Reset in the middle of a frame with a byte buffered and a flag set.
      send_frame(8'h22, 0, 0, 0);
      model_frame(8'h22, 0, 0, 0, 0);
      gap();
      check_state("prerst");
      fork
         send_frame(8'hFF, 0, 0, 1);
         begin
            repeat (300) @(negedge uart_clk);
            uart_rst = 1'b1;
            @(negedge uart_clk);
            uart_rst = 1'b0;
            exp_q.delete();
            m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
            check_state("rst_mid");
            check("rst_mid.data", rx_data, 0);
         end
      join
      gap();
      send_frame(8'h5A, 0, 0, 1);
      model_frame(8'h5A, 0, 0, 0, 1);
      gap();
      check_state("post_rst");
      drain("post_rst");

      // Randomized frames, configurations, pops and clears.
      for (int n = 0; n < 30; n++) begin
         logic [7:0] d;
         bit pen, podd, pbit, stop;
         int npop;
         set_div($urandom_range(1, 3));
         d    = 8'($urandom);
         pen  = 1'($urandom_range(0, 1));
         podd = 1'($urandom_range(0, 1));
         pbit = (^d) ^ podd;
         if ($urandom_range(0, 5) == 0) pbit = ~pbit;
         stop = ($urandom_range(0, 7) != 0);
         cfg_par_en = pen; cfg_par_odd = podd;
         gap();
         send_frame(d, pen, pbit, stop);
         model_frame(d, pen, podd, pbit, stop);
         gap();
         check_state($sformatf("rnd%0d", n));
         npop = $urandom_range(0, exp_q.size());
         repeat (npop) pop_one($sformatf("rnd%0d", n));
         if ($urandom_range(0, 3) == 0) clear_err();
         check_state($sformatf("rnd%0d.post", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
